iob_eth_rx_dma_ctrl: RTL and testbench

//  Sequences the Ethernet RX frame buffer. On each frame-received indication it copies the frame into a ring of NSLOTS memory slots, 4 bytes per write.
//  It posts a {slot,len,err} descriptor to the host, then acks the RX engine so the engine can rearm.

---
 rtl/iob_eth_rx_dma_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_iob_eth_rx_dma_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_rx_dma_ctrl.sv
// Ethernet RX frame-buffer DMA sequencer: copies each received frame into a ring of memory slots
// and posts a {slot,len,err} descriptor. Optional macro IOB_ETH_RX_CRC_DROP_EN drops CRC-errored frames.
module iob_eth_rx_dma_ctrl #(
  parameter int ADDR_W = 32,
  parameter int NSLOTS = 4,
  parameter int SLOT_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              rx_rcvd_i,
  input  logic              rx_crc_err_i,
  input  logic [10:0]       rx_len_i,
  output logic              rx_ack_o,
  output logic [10:0]       buf_addr_o,
  input  logic [7:0]        buf_rdata_i,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_ready_i,
  output logic              desc_valid_o,
  output logic [3:0]        desc_slot_o,
  output logic [10:0]       desc_len_o,
  output logic              desc_err_o,
  input  logic              desc_ready_i,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  // state   | meaning
  // S_IDLE  | waiting for a received frame
  // S_CHECK | decide copy or drop, latch len/err
  // S_READ  | buffer address = byte index
  // S_PACK  | place returned byte into its lane
  // S_WRITE | memory write held until accepted
  // S_DESC  | push descriptor, advance write slot
  // S_ACK   | one-cycle ack to the RX engine
  // S_WAIT  | wait for rx_rcvd_i to fall
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_PACK, S_WRITE, S_DESC, S_ACK, S_WAIT
  } state_t;

  localparam int PW = $clog2(NSLOTS);
  localparam int CW = PW + 1;

  state_t              state_q;
  logic [10:0]         idx_q;
  logic [10:0]         len_q;
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic [CNT_W-1:0]    drop_q;
  logic [10:0]         len_mem_q [NSLOTS];
  logic                rx_ack_q;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
`ifndef IOB_ETH_RX_CRC_DROP_EN
  logic                err_q;
  logic                err_mem_q [NSLOTS];
`endif

  logic       push;
  logic       pop;
  logic       drop;
  logic       last;
  logic [1:0] lane;

  assign lane    = idx_q[1:0];
  assign last    = (idx_q == len_q - 11'd1);
  assign push    = (state_q == S_DESC);
  assign pop     = (count_q != '0) && desc_ready_i;
  assign count_d = count_q + CW'(push) - CW'(pop);

`ifdef IOB_ETH_RX_CRC_DROP_EN
  assign drop = !en_i || (count_q == CW'(NSLOTS)) || (rx_len_i == 11'd0) || rx_crc_err_i;
`else
  assign drop = !en_i || (count_q == CW'(NSLOTS)) || (rx_len_i == 11'd0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      rx_ack_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
`ifndef IOB_ETH_RX_CRC_DROP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      rx_ack_q <= 1'b0;
      count_q  <= count_d;
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case (state_q)
        S_IDLE: if (rx_rcvd_i) state_q <= S_CHECK;
        S_CHECK: begin
          if (drop) begin
            if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            rx_ack_q <= 1'b1;
            state_q  <= S_ACK;
          end else begin
            len_q   <= rx_len_i;
`ifndef IOB_ETH_RX_CRC_DROP_EN
            err_q   <= rx_crc_err_i;
`endif
            idx_q   <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: state_q <= S_PACK;
        S_PACK: begin
          // a new word starts from zero so unused upper lanes of a tail word read as 0
          if (lane == 2'd0) wdata_q <= {24'h0, buf_rdata_i};
          else              wdata_q[8*lane +: 8] <= buf_rdata_i;
          if (lane == 2'd3 || last) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= base_i + (ADDR_W'(wr_ptr_q) << SLOT_W) + ADDR_W'({idx_q[10:2], 2'b00});
            wstrb_q     <= 4'hF >> (2'd3 - lane);
            state_q     <= S_WRITE;
          end else begin
            idx_q   <= idx_q + 11'd1;
            state_q <= S_READ;
          end
        end
        S_WRITE: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            if (last) begin
              state_q <= S_DESC;
            end else begin
              idx_q   <= idx_q + 11'd1;
              state_q <= S_READ;
            end
          end
        end
        S_DESC: begin
          len_mem_q[wr_ptr_q] <= len_q;
`ifndef IOB_ETH_RX_CRC_DROP_EN
          err_mem_q[wr_ptr_q] <= err_q;
`endif
          wr_ptr_q <= wr_ptr_q + PW'(1);
          rx_ack_q <= 1'b1;
          state_q  <= S_ACK;
        end
        S_ACK:  state_q <= S_WAIT;
        S_WAIT: if (!rx_rcvd_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // slot index equals FIFO index, so the head slot is the read pointer
  assign rx_ack_o     = rx_ack_q;
  assign buf_addr_o   = idx_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wstrb_o  = wstrb_q;
  assign desc_valid_o = (count_q != '0);
  assign desc_slot_o  = desc_valid_o ? 4'(rd_ptr_q) : 4'h0;
  assign desc_len_o   = desc_valid_o ? len_mem_q[rd_ptr_q] : 11'h0;
`ifdef IOB_ETH_RX_CRC_DROP_EN
  assign desc_err_o   = 1'b0;
`else
  assign desc_err_o   = desc_valid_o ? err_mem_q[rd_ptr_q] : 1'b0;
`endif
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_iob_eth_rx_dma_ctrl.sv
// Testbench for iob_eth_rx_dma_ctrl: random frames checked against a frame-level
// model of the memory writes, descriptor FIFO and drop counter.
`timescale 1ns/1ps
module tb_iob_eth_rx_dma_ctrl;
  localparam int ADDR_W = 32;
  localparam int NSLOTS = 4;
  localparam int SLOT_W = 11;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [3:0]  slot;
    logic [10:0] len;
    logic        err;
  } desc_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              en_i = 1'b0;
  logic [ADDR_W-1:0] base_i = '0;
  logic              rx_rcvd_i = 1'b0;
  logic              rx_crc_err_i = 1'b0;
  logic [10:0]       rx_len_i = '0;
  logic              rx_ack_o;
  logic [10:0]       buf_addr_o;
  logic [7:0]        buf_rdata_i = '0;
  logic              mem_valid_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wstrb_o;
  logic              mem_ready_i = 1'b1;
  logic              desc_valid_o;
  logic [3:0]        desc_slot_o;
  logic [10:0]       desc_len_o;
  logic              desc_err_o;
  logic              desc_ready_i = 1'b0;
  logic [CNT_W-1:0]  drop_cnt_o;

  iob_eth_rx_dma_ctrl #(.ADDR_W(ADDR_W), .NSLOTS(NSLOTS), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .base_i(base_i),
    .rx_rcvd_i(rx_rcvd_i), .rx_crc_err_i(rx_crc_err_i), .rx_len_i(rx_len_i), .rx_ack_o(rx_ack_o),
    .buf_addr_o(buf_addr_o), .buf_rdata_i(buf_rdata_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .desc_valid_o(desc_valid_o), .desc_slot_o(desc_slot_o), .desc_len_o(desc_len_o),
    .desc_err_o(desc_err_o), .desc_ready_i(desc_ready_i), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] buf_mem [2048];
  always @(posedge clk_i) buf_rdata_i <= buf_mem[buf_addr_o];

  wire [113:0] all_outs = {rx_ack_o, buf_addr_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
                           desc_valid_o, desc_slot_o, desc_len_o, desc_err_o, drop_cnt_o};

  int n_cmp = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int stall_viol = 0;
  bit stall_mode = 0;
  logic [67:0] wr_q [$];
  logic [67:0] exp_wr [$];
  desc_t exp_desc [$];
  int m_count = 0, m_wr = 0, m_drop = 0;

  logic        prev_stall = 1'b0;
  logic [67:0] prev_v = '0;
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      prev_stall = 1'b0;
    end else begin
      if (rx_ack_o) ack_cnt++;
      if (mem_valid_o && mem_ready_i) wr_q.push_back({mem_addr_o, mem_wdata_o, mem_wstrb_o});
      if (prev_stall && (!mem_valid_o || {mem_addr_o, mem_wdata_o, mem_wstrb_o} !== prev_v)) stall_viol++;
      prev_stall = mem_valid_o && !mem_ready_i;
      prev_v     = {mem_addr_o, mem_wdata_o, mem_wstrb_o};
    end
  end

  initial forever begin
    @(posedge clk_i); #2;
    mem_ready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) buf_mem[i] = 8'($urandom);
  endtask

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_drop = 0;
    exp_desc.delete();
  endtask

  task automatic model_frame(input int len, input bit err);
    bit    drop;
    int    nw;
    logic [31:0] d;
    logic [3:0]  s;
    desc_t e;
    drop = !en_i || (m_count == NSLOTS) || (len == 0);
`ifdef IOB_ETH_RX_CRC_DROP_EN
    drop = drop || err;
`endif
    exp_wr.delete();
    if (drop) begin
      if (m_drop < (1 << CNT_W) - 1) m_drop++;
    end else begin
      nw = (len + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        d = '0;
        for (int b = 0; b < 4; b++) if (4*w + b < len) d[8*b +: 8] = buf_mem[4*w + b];
        s = (w == nw - 1 && len % 4 != 0) ? 4'((1 << (len % 4)) - 1) : 4'hF;
        exp_wr.push_back({base_i + 32'(m_wr * (1 << SLOT_W)) + 32'(4*w), d, s});
      end
      e.slot = 4'(m_wr); e.len = 11'(len); e.err = err;
      exp_desc.push_back(e);
      m_wr = (m_wr + 1) % NSLOTS;
      m_count++;
    end
  endtask

  task automatic run_frame(input int len, input bit err);
    int ack0, cyc;
    model_frame(len, err);
    wr_q.delete();
    ack0 = ack_cnt;
    @(posedge clk_i); #2;
    rx_len_i = 11'(len); rx_crc_err_i = err; rx_rcvd_i = 1'b1;
    cyc = 0;
    while (ack_cnt == ack0 && cyc < 4000) begin @(negedge clk_i); cyc++; end
    n_cmp++;
    if (ack_cnt == ack0) begin
      n_fail++; $display("FAIL ack_timeout: no rx_ack_o within %0d cycles, required one pulse (len=%0d)", cyc, len);
    end
    repeat ($urandom_range(0, 8)) @(posedge clk_i);
    @(posedge clk_i); #2 rx_rcvd_i = 1'b0;
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if (ack_cnt - ack0 != 1) begin
      n_fail++; $display("FAIL ack_pulses: got %0d cycles of rx_ack_o, required 1 (len=%0d)", ack_cnt - ack0, len);
    end
    n_cmp++;
    if (wr_q.size() != exp_wr.size()) begin
      n_fail++; $display("FAIL write_count: got %0d writes, required %0d (len=%0d)", wr_q.size(), exp_wr.size(), len);
    end
    for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++) begin
      n_cmp++;
      if (wr_q[k] !== exp_wr[k]) begin
        n_fail++; $display("FAIL write_%0d: got addr/data/strb %h, required %h", k, wr_q[k], exp_wr[k]);
      end
    end
    n_cmp++;
    if (drop_cnt_o !== CNT_W'(m_drop)) begin
      n_fail++; $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt_o, m_drop);
    end
    n_cmp++;
    if (desc_valid_o !== (m_count != 0)) begin
      n_fail++; $display("FAIL desc_valid: got %b, required %b", desc_valid_o, m_count != 0);
    end
  endtask

  task automatic pop_desc();
    desc_t e;
    @(negedge clk_i);
    n_cmp++;
    if (desc_valid_o !== 1'b1 || exp_desc.size() == 0) begin
      n_fail++; $display("FAIL pop_valid: got desc_valid %b, required 1 (model entries %0d)", desc_valid_o, exp_desc.size());
    end else begin
      e = exp_desc.pop_front();
`ifdef IOB_ETH_RX_CRC_DROP_EN
      e.err = 1'b0;
`endif
      n_cmp++;
      if ({desc_slot_o, desc_len_o, desc_err_o} !== e) begin
        n_fail++; $display("FAIL desc_head: got slot %0d len %0d err %b, required slot %0d len %0d err %b",
                           desc_slot_o, desc_len_o, desc_err_o, e.slot, e.len, e.err);
      end
      @(posedge clk_i); #2 desc_ready_i = 1'b1;
      @(posedge clk_i); #2 desc_ready_i = 1'b0;
      m_count--;
    end
  endtask

  task automatic drain();
    while (exp_desc.size() > 0) pop_desc();
  endtask

  task automatic test_reset();
    @(posedge clk_i); #2 rst_n_i = 1'b0; desc_ready_i = 1'b0; rx_rcvd_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0", all_outs);
    end
    @(posedge clk_i); #2 rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    fill_rand(64);
    run_frame(64, 1'b0);
    pop_desc();
  endtask

  task automatic test_short();
    buf_mem[0] = 8'h11; buf_mem[1] = 8'h22; buf_mem[2] = 8'h33; buf_mem[3] = 8'h44; buf_mem[4] = 8'h55;
    run_frame(5, 1'b0);
    pop_desc();
  endtask

  task automatic test_ring_full();
    for (int k = 0; k < NSLOTS; k++) begin
      fill_rand(40);
      run_frame($urandom_range(1, 40), 1'b0);
    end
    fill_rand(20);
    run_frame(20, 1'b0);
    pop_desc();
    fill_rand(30);
    run_frame($urandom_range(1, 30), 1'b0);
    drain();
  endtask

  task automatic test_crc_err();
    fill_rand(64);
    run_frame(64, 1'b1);
    drain();
  endtask

  task automatic test_drop_cases();
    en_i = 1'b0;
    fill_rand(20);
    run_frame(20, 1'b0);
    en_i = 1'b1;
    run_frame(0, 1'b0);
    @(posedge clk_i); #2 desc_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2 desc_ready_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (desc_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL empty_pop: got desc_valid %b, required 0", desc_valid_o);
    end
    fill_rand(7);
    run_frame(7, 1'b0);
    drain();
  endtask

  task automatic test_stall();
    stall_mode = 1;
    for (int k = 0; k < 6; k++) begin
      fill_rand(120);
      run_frame($urandom_range(1, 120), 1'($urandom_range(0, 1)));
      if (k % 2 == 1) drain();
    end
    drain();
    stall_mode = 0;
    n_cmp++;
    if (stall_viol != 0) begin
      n_fail++; $display("FAIL stall_stable: got %0d unstable stalled cycles, required 0", stall_viol);
    end
  endtask

  task automatic test_reset_mid_copy();
    int ack0, cyc;
    fill_rand(64);
    ack0 = ack_cnt;
    @(posedge clk_i); #2;
    rx_len_i = 11'd64; rx_crc_err_i = 1'b0; rx_rcvd_i = 1'b1;
    cyc = 0;
    while ((cyc < 3 || buf_addr_o != 11'd30 || mem_valid_o) && cyc < 1000) begin @(negedge clk_i); cyc++; end
    n_cmp++;
    if (buf_addr_o != 11'd30) begin
      n_fail++; $display("FAIL midcopy_reach: got buf_addr %0d, required 30", buf_addr_o);
    end
    @(posedge clk_i); #2 rst_n_i = 1'b0; rx_rcvd_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL midcopy_outputs: got %h, required 0", all_outs);
    end
    @(posedge clk_i); #2 rst_n_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (ack_cnt != ack0) begin
      n_fail++; $display("FAIL midcopy_ack: got %0d ack cycles, required 0", ack_cnt - ack0);
    end
    fill_rand(50);
    run_frame(50, 1'b0);
    drain();
  endtask

  initial begin
    base_i = $urandom & 32'hFFFF_FFFC;
    en_i = 1'b1;
    test_reset();
    test_basic();
    test_short();
    test_reset();
    test_ring_full();
    test_crc_err();
    test_drop_cases();
    test_stall();
    test_reset_mid_copy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
